// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU datapath.
// Holds default widths, phase and opcode widths, and the opcode encoding
// used by the controller, the ALU and the datapath.
package cpu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;
  localparam int PHASE_W    = 3;
  localparam int OPC_W      = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_HLT = 3'b000,
    OP_SKZ = 3'b001,
    OP_ADD = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_LDA = 3'b101,
    OP_STO = 3'b110,
    OP_JMP = 3'b111
  } opcode_e;

endpackage

// File: rtl/cpu_datapath_alu.sv
// Combinational ALU for the accumulator CPU.
// Ports:
//   opcode  - instruction opcode (IR top bits)
//   ac      - accumulator operand
//   data    - memory read data operand
//   alu_out - result; opcodes without an ALU function pass the accumulator
module alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] ac,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] alu_out
);

  always_comb begin
    // NOTE: default assigned first so no path through the case leaves
    // alu_out unassigned, which would infer a latch.
    alu_out = ac;
    case (opcode_e'(opcode))
      OP_ADD:  alu_out = ac + data;   // carry out discarded
      OP_AND:  alu_out = ac & data;
      OP_XOR:  alu_out = ac ^ data;
      OP_LDA:  alu_out = data;
      default: alu_out = ac;
    endcase
  end

endmodule

// File: rtl/cpu_datapath.sv
// Accumulator CPU datapath: phase counter, PC, IR, AC, halt flag, address
// mux and memory interface. Strobes come from an external controller.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   sel .. data_e      - controller strobes
//   mem_rdata          - memory read data
//   phase              - current instruction phase (registered)
//   opcode             - IR opcode field
//   zero               - accumulator is zero
//   mem_addr           - PC when sel=1, IR operand field otherwise
//   mem_rd, mem_wr     - copies of rd, wr
//   mem_wdata          - accumulator value, qualified by mem_wdata_oe
//   halted             - halt status (registered)
module cpu_datapath
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sel,
  input  logic               rd,
  input  logic               ld_ir,
  input  logic               halt,
  input  logic               inc_pc,
  input  logic               ld_ac,
  input  logic               ld_pc,
  input  logic               wr,
  input  logic               data_e,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [PHASE_W-1:0] phase,
  output logic [OPC_W-1:0]   opcode,
  output logic               zero,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_wdata_oe,
  output logic               halted
);

  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] ac;
  logic [DATA_W-1:0] alu_out;

  alu #(.DATA_W(DATA_W)) u_alu (
    .opcode  (opcode),
    .ac      (ac),
    .data    (mem_rdata),
    .alu_out (alu_out)
  );

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values (e.g. PC loads from the old IR on the edge IR loads).
  always_ff @(posedge clk) begin
    if (rst) begin
      phase  <= '0;
      pc     <= '0;
      ir     <= '0;
      ac     <= '0;
      halted <= 1'b0;
    end else if (!halted) begin
      // The halting edge freezes the phase but still honours the other
      // strobes of that cycle; afterwards everything is frozen.
      if (halt) halted <= 1'b1;
      else      phase  <= phase + 1'b1;

      if (ld_pc)       pc <= ir[ADDR_W-1:0];
      else if (inc_pc) pc <= pc + 1'b1;

      if (ld_ir) ir <= mem_rdata;
      if (ld_ac) ac <= alu_out;
    end
  end

  assign opcode       = ir[DATA_W-1:DATA_W-OPC_W];
  assign zero         = (ac == '0);
  assign mem_addr     = sel ? pc : ir[ADDR_W-1:0];
  assign mem_rd       = rd;
  assign mem_wr       = wr;
  assign mem_wdata    = ac;
  assign mem_wdata_oe = data_e;

endmodule

// File: tb/tb_cpu_datapath.sv
// Scoreboard bench for cpu_datapath: a driver applies one strobe set per
// cycle, pushes the outputs a behavioural model expects for that cycle and
// advances the model; a monitor pops and compares once outputs settle.
module tb_cpu_datapath;

  // strobe bit positions
  localparam logic [8:0] S_SEL = 9'h001, S_RD = 9'h002, S_LDIR = 9'h004,
                         S_HALT = 9'h008, S_INC = 9'h010, S_LDAC = 9'h020,
                         S_LDPC = 9'h040, S_WR = 9'h080, S_DE = 9'h100,
                         S_ALL = 9'h1FF;

  typedef struct packed {
    logic [2:0] phase;
    logic [2:0] opcode;
    logic       zero;
    logic [4:0] addr;
    logic       rd;
    logic       wr;
    logic [7:0] wdata;
    logic       oe;
    logic       halted;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0, rd = 1'b0, ld_ir = 1'b0, halt = 1'b0, inc_pc = 1'b0;
  logic       ld_ac = 1'b0, ld_pc = 1'b0, wr = 1'b0, data_e = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic [2:0] phase, opcode;
  logic       zero, mem_rd, mem_wr, mem_wdata_oe, halted;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;

  cpu_datapath #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .sel(sel), .rd(rd), .ld_ir(ld_ir), .halt(halt),
    .inc_pc(inc_pc), .ld_ac(ld_ac), .ld_pc(ld_pc), .wr(wr), .data_e(data_e),
    .mem_rdata(mem_rdata), .phase(phase), .opcode(opcode), .zero(zero),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe), .halted(halted)
  );

  always #5 clk = ~clk;

  outs_t exp_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  // reference state as plain integers
  int m_phase, m_pc, m_ir, m_ac;
  bit m_halted;

  function automatic int alu_ref(int op, int a, int d);
    case (op)
      2:       return (a + d) % 256;
      3:       return a & d;
      4:       return a ^ d;
      5:       return d;
      default: return a;
    endcase
  endfunction

  task automatic check(input string name, input outs_t act, input outs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got ph=%0d op=%0d z=%0b addr=%0d rd=%0b wr=%0b wd=%02h oe=%0b hlt=%0b, want ph=%0d op=%0d z=%0b addr=%0d rd=%0b wr=%0b wd=%02h oe=%0b hlt=%0b",
               name, act.phase, act.opcode, act.zero, act.addr, act.rd, act.wr,
               act.wdata, act.oe, act.halted, exp.phase, exp.opcode, exp.zero,
               exp.addr, exp.rd, exp.wr, exp.wdata, exp.oe, exp.halted);
    end
  endtask

  // Apply one cycle of stimulus, record the expected outputs for it, then
  // advance the model across the following rising edge.
  task automatic step(input string name, input logic r, input logic [8:0] s,
                      input logic [7:0] d);
    outs_t e;
    int n_phase, n_pc, n_ir, n_ac;
    bit n_halted;
    @(negedge clk);
    rst = r;
    sel = s[0]; rd = s[1]; ld_ir = s[2]; halt = s[3]; inc_pc = s[4];
    ld_ac = s[5]; ld_pc = s[6]; wr = s[7]; data_e = s[8];
    mem_rdata = d;

    e.phase  = 3'(m_phase);
    e.opcode = 3'(m_ir / 32);
    e.zero   = (m_ac == 0);
    e.addr   = s[0] ? 5'(m_pc) : 5'(m_ir % 32);
    e.rd     = s[1];
    e.wr     = s[7];
    e.wdata  = 8'(m_ac);
    e.oe     = s[8];
    e.halted = m_halted;
    exp_q.push_back(e);
    name_q.push_back(name);

    n_phase = m_phase; n_pc = m_pc; n_ir = m_ir; n_ac = m_ac; n_halted = m_halted;
    if (r) begin
      n_phase = 0; n_pc = 0; n_ir = 0; n_ac = 0; n_halted = 0;
    end else if (!m_halted) begin
      if (s[3]) n_halted = 1;
      else      n_phase = (m_phase + 1) % 8;
      if (s[6])      n_pc = m_ir % 32;
      else if (s[4]) n_pc = (m_pc + 1) % 32;
      if (s[2]) n_ir = int'(d);
      if (s[5]) n_ac = alu_ref(m_ir / 32, m_ac, int'(d));
    end
    m_phase = n_phase; m_pc = n_pc; m_ir = n_ir; m_ac = n_ac; m_halted = n_halted;
  endtask

  // monitor: outputs settle 2 time units after the driver's negedge update
  initial begin
    outs_t act;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        act = '{phase: phase, opcode: opcode, zero: zero, addr: mem_addr,
                rd: mem_rd, wr: mem_wr, wdata: mem_wdata, oe: mem_wdata_oe,
                halted: halted};
        check(name_q.pop_front(), act, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [8:0] s;
    @(posedge clk);
    #1;
    m_phase = 0; m_pc = 0; m_ir = 0; m_ac = 0; m_halted = 0;

    // reset state and free-running phase counter with idle strobes
    for (int i = 0; i < 9; i++) step($sformatf("idle_%0d", i), 1'b0, S_SEL, 8'h00);

    // ADD with carry out, then XOR to zero
    step("rst_a", 1'b1, 9'h000, 8'h00);
    step("lda_ir", 1'b0, S_SEL | S_LDIR, 8'hA0);
    step("lda_0f", 1'b0, S_SEL | S_LDAC, 8'h0F);
    step("add_ir", 1'b0, S_SEL | S_LDIR, 8'h40);
    step("add_f3", 1'b0, S_SEL | S_LDAC, 8'hF3);
    step("add_res", 1'b0, S_SEL | S_LDIR, 8'hA0);
    step("lda_5a", 1'b0, S_SEL | S_LDAC, 8'h5A);
    step("xor_ir", 1'b0, S_SEL | S_LDIR, 8'h80);
    step("xor_5a", 1'b0, S_SEL | S_LDAC, 8'h5A);
    step("xor_res", 1'b0, S_SEL, 8'h00);

    // PC wrap and ld_pc priority
    step("ir_1f", 1'b0, S_SEL | S_LDIR, 8'h1F);
    step("pc_31", 1'b0, S_SEL | S_LDPC, 8'h00);
    step("pc_wrap", 1'b0, S_SEL | S_INC, 8'h00);
    step("ir_e9", 1'b0, S_SEL | S_LDIR, 8'hE9);
    step("pc_prio", 1'b0, S_SEL | S_LDPC | S_INC, 8'h00);
    step("pc_9", 1'b0, S_SEL, 8'h00);

    // halt at phase 4 with inc_pc, then frozen, then reset clears
    step("rst_h", 1'b1, 9'h000, 8'h00);
    step("h_inc0", 1'b0, S_SEL | S_INC, 8'h00);
    step("h_inc1", 1'b0, S_SEL | S_INC, 8'h00);
    step("h_inc2", 1'b0, S_SEL | S_INC, 8'h00);
    step("h_idle3", 1'b0, S_SEL, 8'h00);
    step("h_halt4", 1'b0, S_SEL | S_HALT | S_INC, 8'h00);
    for (int i = 0; i < 10; i++)
      step($sformatf("h_frozen_%0d", i), 1'b0, S_ALL, 8'($urandom_range(0, 255)));
    step("h_rst", 1'b1, S_ALL, 8'h00);
    step("h_after", 1'b0, S_SEL, 8'h00);

    // store path: operand address and accumulator on the write bus
    step("st_lda_ir", 1'b0, S_SEL | S_LDIR, 8'hA0);
    step("st_lda", 1'b0, S_SEL | S_LDAC, 8'hA5);
    step("st_ir_d7", 1'b0, S_SEL | S_LDIR, 8'hD7);
    step("st_write", 1'b0, S_WR | S_DE, 8'h00);

    // reset mid-instruction with ld_pc at phase 6
    step("rst_m", 1'b1, 9'h000, 8'h00);
    step("m_ir", 1'b0, S_SEL | S_LDIR, 8'hA0);
    step("m_ac", 1'b0, S_SEL | S_LDAC, 8'h3C);
    step("m_ir2", 1'b0, S_SEL | S_LDIR, 8'h2E);
    step("m_p3", 1'b0, S_SEL, 8'h00);
    step("m_p4", 1'b0, S_SEL, 8'h00);
    step("m_p5", 1'b0, S_SEL, 8'h00);
    step("m_rst6", 1'b1, S_SEL | S_LDPC | S_LDAC | S_HALT, 8'h11);
    step("m_after", 1'b0, S_SEL, 8'h00);

    // randomized strobes with occasional halt and reset
    for (int i = 0; i < 400; i++) begin
      s = 9'($urandom);
      if ($urandom_range(0, 31) != 0) s[3] = 1'b0;
      step($sformatf("rand_%0d", i), ($urandom_range(0, 19) == 0), s,
           8'($urandom_range(0, 255)));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #5;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
